// File: rtl/ffn_out_collector_pkg.sv
// Shared types and helpers for the FFN output collector.
// Width/class-count defaults normally arrive from network_params.h; the
// guarded fallbacks below only apply when that header was not included.
`ifndef FFN_OUT_WIDTH
`define FFN_OUT_WIDTH 16
`endif
`ifndef NUM_CLASSES
`define NUM_CLASSES 10
`endif

package ffn_out_collector_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with enable, synchronous clear and terminal-count flag.
module mod_counter
  import ffn_out_collector_pkg::*;
#(
  parameter int unsigned MOD = 10,
  parameter int unsigned CW  = idx_width(MOD)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          tc_c
);

  // Terminal count is a decode of the current value.
  assign tc_c = (count == CW'(MOD - 1));

  // Count register: reset/clear win, otherwise wrap at MOD-1 when enabled.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      if (tc_c) count <= '0;
      else      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ffn_out_collector.sv
// Gathers N per-class scores into one packed frame and hands it downstream.
module ffn_out_collector
  import ffn_out_collector_pkg::*;
#(
  parameter int unsigned W = `FFN_OUT_WIDTH,
  parameter int unsigned N = `NUM_CLASSES
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           in_ready,
  output logic [W*N-1:0] out_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           frame_err
);

  localparam int unsigned IW = idx_width(N);

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   idx;
  logic            idx_tc;
  logic            accept;
  logic            frame_ok;
  logic            frame_bad;

  // A frame is well formed only when in_last coincides with the final class.
  assign accept    = in_valid & in_ready;
  assign frame_ok  = accept & idx_tc & in_last;
  assign frame_bad = accept & (idx_tc ^ in_last);

  mod_counter #(
    .MOD (N),
    .CW  (IW)
  ) u_idx (
    .clock (clock),
    .reset (reset),
    .en    (accept),
    .clear (frame_ok | frame_bad),
    .count (idx),
    .tc_c  (idx_tc)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= COLLECT;
    else       state <= state_nx;
  end

  // Next-state logic: complete frame enters HOLD, consume returns to COLLECT.
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (frame_ok)  state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  // One-cycle pulse for a discarded, malformed frame.
  always_ff @(posedge clock) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= frame_bad;
  end

  // Slot write: accepted beats land in slot idx; nothing else clears slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_vec <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (accept && (idx == IW'(k))) out_vec[k*W +: W] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_ffn_out_collector.sv
// Directed, table-driven bench for ffn_out_collector (W=8, N=10).
module tb_ffn_out_collector;

  localparam int unsigned W = 8;
  localparam int unsigned N = 10;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_ready;
  logic [W*N-1:0] out_vec;
  logic           out_valid;
  logic           out_ready;
  logic           frame_err;

  int nvec;
  int nerr;

  typedef struct {
    logic           rst;
    logic           iv;
    logic [W-1:0]   d;
    logic           last;
    logic           ordy;
    logic           ir;
    logic           ov;
    logic           fe;
    logic           chk;
    logic [W*N-1:0] vec;
  } vec_t;

  vec_t tbl[$];

  ffn_out_collector #(.W(W), .N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Frame whose slot k holds base+k.
  function automatic logic [W*N-1:0] seqv(input int base);
    logic [W*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  function automatic void add(input logic rst, input logic iv, input int d,
                              input logic last, input logic ordy,
                              input logic ir, input logic ov, input logic fe,
                              input logic chk, input logic [W*N-1:0] vec);
    vec_t e;
    e.rst = rst; e.iv = iv; e.d = W'(d); e.last = last; e.ordy = ordy;
    e.ir = ir; e.ov = ov; e.fe = fe; e.chk = chk; e.vec = vec;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [W*N-1:0] act,
                     input logic [W*N-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rst, input logic iv, input int d,
                       input logic last, input logic ordy);
    reset = rst; in_valid = iv; in_data = W'(d); in_last = last; out_ready = ordy;
  endtask

  task automatic chk_hs(input string nm, input logic ir, input logic ov, input logic fe);
    chk({nm, " in_ready"},  (W*N)'(in_ready),  (W*N)'(ir));
    chk({nm, " out_valid"}, (W*N)'(out_valid), (W*N)'(ov));
    chk({nm, " frame_err"}, (W*N)'(frame_err), (W*N)'(fe));
  endtask

  initial begin
    logic [W*N-1:0] five_ten;
    logic [W*N-1:0] snap;
    nvec = 0;
    nerr = 0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    five_ten = {{9{8'd5}}, 8'd10};

    // Reset, then a clean frame 1..10 consumed immediately.
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, '0);
    for (int k = 0; k < 10; k++)
      add(0, 1, k + 1, k == 9, 1, k != 9, k == 9, 0, k == 9, seqv(1));
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    // Early in_last on beat 4, then a good frame {5 x9, 10}.
    for (int k = 0; k < 4; k++)
      add(0, 1, 7, k == 3, 1, 1, 0, k == 3, 0, '0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    for (int k = 0; k < 10; k++)
      add(0, 1, (k == 0) ? 10 : 5, k == 9, 1, k != 9, k == 9, 0, k == 9, five_ten);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    // Ten beats without in_last: error pulse, no out_valid, slots kept.
    for (int k = 0; k < 10; k++)
      add(0, 1, 20 + k, 0, 1, 1, 0, k == 9, 0, '0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, seqv(20));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, int'(tbl[i].d), tbl[i].last, tbl[i].ordy);
      tick();
      chk_hs($sformatf("v%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].fe);
      if (tbl[i].chk) chk($sformatf("v%0d out_vec", i), out_vec, tbl[i].vec);
    end

    // Frame held 5 cycles with out_ready low while in_valid keeps pushing.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 31 + k, k == 9, 1'b0);
      tick();
    end
    chk_hs("hold entry", 1'b0, 1'b1, 1'b0);
    snap = seqv(31);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
      tick();
      chk_hs($sformatf("hold c%0d", c), 1'b0, 1'b1, 1'b0);
      chk($sformatf("hold c%0d out_vec", c), out_vec, snap);
    end
    drive(1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
    tick();
    chk_hs("consume", 1'b1, 1'b0, 1'b0);
    chk("consume out_vec", out_vec, snap);

    // Reset after beat 6, asserted together with another beat.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 50 + k, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 56, 1'b0, 1'b1);
    tick();
    chk_hs("mid rst", 1'b1, 1'b0, 1'b0);
    chk("mid rst out_vec", out_vec, '0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 60 + k, k == 9, 1'b0);
      tick();
    end
    chk_hs("after rst frame", 1'b0, 1'b1, 1'b0);
    chk("after rst out_vec", out_vec, seqv(60));
    // Reset while holding.
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_hs("hold rst", 1'b1, 1'b0, 1'b0);
    chk("hold rst out_vec", out_vec, '0);

    // in_valid every other cycle; idle cycles carry junk and in_last.
    begin
      int n;
      n = 0;
      for (int c = 0; c < 20; c++) begin
        if (c % 2 == 0) begin
          drive(1'b0, 1'b1, 70 + n, n == 9, 1'b0);
          n++;
        end else begin
          drive(1'b0, 1'b0, 8'hEE, 1'b1, 1'b0);
        end
        tick();
        chk($sformatf("toggle c%0d out_valid", c), (W*N)'(out_valid), (W*N)'(c >= 18));
      end
    end
    chk("toggle out_vec", out_vec, seqv(70));
    chk("toggle frame_err", (W*N)'(frame_err), '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
